// File: rtl/pipe_spawner_if.sv
// Handshake bundle between the pipe spawner, its height generator and the draw/score logic.
// The slave modport is the spawner's view; the master modport is the environment's view.
interface pipe_spawner_if;
  logic        run;
  logic        frame_tick;
  logic [15:0] random_number;
  logic        is_active;
  logic [10:0] pipe_x;
  logic [9:0]  gap_y;
  logic        pipe_valid;
  logic        passed;

  modport master (
    output run, frame_tick, random_number,
    input  is_active, pipe_x, gap_y, pipe_valid, passed
  );

  modport slave (
    input  run, frame_tick, random_number,
    output is_active, pipe_x, gap_y, pipe_valid, passed
  );
endinterface

// File: rtl/pipe_spawner.sv
// Requests a random gap height, clamps it, and scrolls one pipe leftward per frame tick,
// respawning at the right edge once it leaves the screen.
module pipe_spawner #(
  parameter int unsigned START_X = 640,
  parameter int unsigned PIPE_W  = 60,
  parameter int unsigned BIRD_X  = 160,
  parameter int unsigned STEP    = 2,
  parameter int unsigned GAP_MIN = 220,
  parameter int unsigned GAP_MAX = 440
) (
  input  logic          clk,
  input  logic          reset,
  pipe_spawner_if.slave bus
);

  localparam logic [10:0] StartX  = 11'(START_X);
  localparam logic [10:0] StepX   = 11'(STEP);
  localparam logic [11:0] PipeW12 = 12'(PIPE_W);
  localparam logic [11:0] BirdX12 = 12'(BIRD_X);
  localparam logic [11:0] Step12  = 12'(STEP);
  localparam logic [15:0] GapMin  = 16'(GAP_MIN);
  localparam logic [15:0] GapMax  = 16'(GAP_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StCap, StScroll} state_e;

  state_e      state_q, state_d;
  logic [10:0] pipe_x_q, pipe_x_d;
  logic [9:0]  gap_y_q, gap_y_d;
  logic        pipe_valid_q, pipe_valid_d;
  logic        passed_q, passed_d;

  logic        tick;
  logic        respawn;
  logic        move;
  logic [11:0] x_ext;
  logic [11:0] trail_new;
  logic [11:0] trail_old;
  logic [9:0]  gap_clamped;

  assign tick    = bus.frame_tick & bus.run;
  assign respawn = (state_q == StScroll) && tick && (pipe_x_q <= StepX);
  assign move    = (state_q == StScroll) && tick && (pipe_x_q > StepX);

  // Right-edge positions before/after the move; only evaluated when pipe_x > STEP.
  assign x_ext     = {1'b0, pipe_x_q};
  assign trail_new = x_ext - Step12 + PipeW12;
  assign trail_old = x_ext + PipeW12;

  always_comb begin
    gap_clamped = bus.random_number[9:0];
    if (bus.random_number < GapMin) begin
      gap_clamped = GapMin[9:0];
    end else if (bus.random_number > GapMax) begin
      gap_clamped = GapMax[9:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.run) state_d = StReq;
      StReq:    state_d = StCap;
      StCap:    state_d = StScroll;
      StScroll: if (respawn) state_d = StReq;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    pipe_x_d     = pipe_x_q;
    gap_y_d      = gap_y_q;
    pipe_valid_d = pipe_valid_q;
    passed_d     = 1'b0;
    if (state_q == StCap) begin
      gap_y_d      = gap_clamped;
      pipe_x_d     = StartX;
      pipe_valid_d = 1'b1;
    end else if (respawn) begin
      pipe_valid_d = 1'b0;
    end else if (move) begin
      pipe_x_d = pipe_x_q - StepX;
      passed_d = (trail_new <= BirdX12) && (BirdX12 < trail_old);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_x_q     <= StartX;
      gap_y_q      <= GapMin[9:0];
      pipe_valid_q <= 1'b0;
      passed_q     <= 1'b0;
    end else begin
      pipe_x_q     <= pipe_x_d;
      gap_y_q      <= gap_y_d;
      pipe_valid_q <= pipe_valid_d;
      passed_q     <= passed_d;
    end
  end

  // Moore request: decoded from state alone so the generator steps once per pipe.
  assign bus.is_active  = (state_q == StReq);
  assign bus.pipe_x     = pipe_x_q;
  assign bus.gap_y      = gap_y_q;
  assign bus.pipe_valid = pipe_valid_q;
  assign bus.passed     = passed_q;

endmodule

// File: tb/tb_pipe_spawner.sv
// Directed bench for pipe_spawner: generator stub, immediate-assertion checks, summary line.
module tb_pipe_spawner;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   act_cnt;
  int   pass_cnt;
  logic [15:0] stub_val;

  pipe_spawner_if bus ();

  pipe_spawner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator stub: a new value appears the cycle after is_active.
  always @(posedge clk) begin
    if (bus.is_active) bus.random_number <= stub_val;
    if (bus.is_active) act_cnt <= act_cnt + 1;
    if (bus.passed) pass_cnt <= pass_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(bus.pipe_x), 640);
    check({tag, "_gap"}, 32'(bus.gap_y), 220);
    check({tag, "_valid"}, 32'(bus.pipe_valid), 0);
    check({tag, "_passed"}, 32'(bus.passed), 0);
    check({tag, "_act"}, 32'(bus.is_active), 0);
  endtask

  // Reset, then run and spawn one pipe with the given stub value.
  task automatic spawn(input logic [15:0] val, input int exp_gap, input string tag);
    reset = 1'b1;
    bus.run = 1'b0;
    cyc(1);
    reset = 1'b0;
    stub_val = val;
    bus.run = 1'b1;
    cyc(3);
    check({tag, "_gap"}, 32'(bus.gap_y), 32'(exp_gap));
    check({tag, "_valid"}, 32'(bus.pipe_valid), 1);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    act_cnt = 0;
    pass_cnt = 0;
    stub_val = 16'd0;
    bus.random_number = 16'd0;
    bus.run = 1'b0;
    bus.frame_tick = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;

    // Idle with run low: nothing moves, no requests, ticks ignored.
    for (int i = 0; i < 100; i++) begin
      bus.frame_tick = (i % 7 == 0);
      @(negedge clk);
      check_reset_vals("idle");
    end
    bus.frame_tick = 1'b0;

    // First spawn, 3-edge latency.
    stub_val = 16'd330;
    act_cnt = 0;
    bus.run = 1'b1;
    cyc(1);
    check("req_act", 32'(bus.is_active), 1);
    check("req_valid", 32'(bus.pipe_valid), 0);
    cyc(1);
    check("cap_act", 32'(bus.is_active), 0);
    check("cap_valid", 32'(bus.pipe_valid), 0);
    cyc(1);
    check("spawn_gap", 32'(bus.gap_y), 330);
    check("spawn_x", 32'(bus.pipe_x), 640);
    check("spawn_valid", 32'(bus.pipe_valid), 1);
    check("spawn_act_cnt", 32'(act_cnt), 1);

    // Scrolling and freeze.
    ticks(10);
    check("scroll_x", 32'(bus.pipe_x), 620);
    bus.run = 1'b0;
    ticks(5);
    check("freeze_x", 32'(bus.pipe_x), 620);
    check("freeze_valid", 32'(bus.pipe_valid), 1);
    check("freeze_act_cnt", 32'(act_cnt), 1);

    // Reset mid-SCROLL returns everything and parks in IDLE.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_reset_vals("rst");
    cyc(3);
    check_reset_vals("rst_idle");

    // Clamp boundaries.
    spawn(16'd500, 440, "clamp_hi");
    spawn(16'd0, 220, "clamp_lo");
    spawn(16'h80DC, 440, "clamp_wide");
    spawn(16'd220, 220, "clamp_min");
    spawn(16'd440, 440, "clamp_max");
    spawn(16'd219, 220, "clamp_below");

    // Pass detection over a full crossing.
    spawn(16'd300, 300, "pass_spawn");
    pass_cnt = 0;
    ticks(269);
    check("pass_pre_x", 32'(bus.pipe_x), 102);
    check("pass_pre_cnt", 32'(pass_cnt), 0);
    ticks(1);
    check("pass_x", 32'(bus.pipe_x), 100);
    check("pass_pulse", 32'(bus.passed), 1);
    cyc(1);
    check("pass_drop", 32'(bus.passed), 0);
    ticks(49);
    check("wrap_pre_x", 32'(bus.pipe_x), 2);
    check("pass_cnt", 32'(pass_cnt), 1);

    // Respawn at the left edge; ticks during REQ/CAP are dropped.
    stub_val = 16'd250;
    act_cnt = 0;
    bus.frame_tick = 1'b1;
    cyc(1);
    check("wrap_valid", 32'(bus.pipe_valid), 0);
    check("wrap_act", 32'(bus.is_active), 1);
    check("wrap_x_hold", 32'(bus.pipe_x), 2);
    cyc(1);
    check("wrap_cap_act", 32'(bus.is_active), 0);
    cyc(1);
    bus.frame_tick = 1'b0;
    check("wrap_gap", 32'(bus.gap_y), 250);
    check("wrap_x", 32'(bus.pipe_x), 640);
    check("wrap_valid1", 32'(bus.pipe_valid), 1);
    check("wrap_act_cnt", 32'(act_cnt), 1);
    check("wrap_pass_cnt", 32'(pass_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
